sub_serial: RTL

Bit-serial subtractor, the inverse counterpart of the team's combinational n-bit adder with carry-in.
- Computes a - b - b_in one bit per clock, LSB first, under a start/done handshake.
- Returns an (N+1)-bit result whose MSB is the borrow, matching the adder's (N+1)-bit sum convention.
- Intended for FPU exponent-difference and alignment paths where area matters more than latency.

---
 rtl/sub_serial_pkg.sv | 18 +
 rtl/fsub_bit.sv | 14 +
 rtl/sub_serial.sv | 109 ++++++++++
 3 files changed

// File: rtl/sub_serial_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
// Pure declarations; no latency or flow control of its own.
package sub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEFAULT = 10;

  // Bit counter must index 0..n-1; keep at least one bit for tiny n.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fsub_bit.sv
// 1-bit full subtractor: d = a - b - br_in, br_out = borrow.
// Combinational, zero latency; no flow control.
module fsub_bit (
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = a ^ b ^ br_in;
  assign br_out = (~a & b) | (~(a ^ b) & br_in);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial a - b - b_in, LSB first; done pulses N+1 cycles after start, issue interval N+2.
// start ignored while busy (no queueing); optional zero flag under SUB_SERIAL_ZERO_FLAG_EN.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [N:0]   diff
`ifdef SUB_SERIAL_ZERO_FLAG_EN
  ,
  output logic         zero
`endif
);

  localparam int CW = cnt_width(N);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   a_sr, b_sr, d_sr;
  logic           br;
  logic           d_bit, br_nxt;
  logic           last;
  logic [N:0]     res_nxt;

  fsub_bit u_fsub (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .br_in  (br),
    .d      (d_bit),
    .br_out (br_nxt)
  );

  assign last    = (cnt == CW'(N - 1));
  assign res_nxt = {br_nxt, d_bit, d_sr[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // diff is written on the final RUN edge so it is already valid during DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
`ifdef SUB_SERIAL_ZERO_FLAG_EN
      zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            br   <= b_in;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_nxt;
          d_sr <= {d_bit, d_sr[N-1:1]};
          if (last) begin
            diff <= res_nxt;
`ifdef SUB_SERIAL_ZERO_FLAG_EN
            zero <= (res_nxt == '0);
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
